// File: rtl/chacha_pkg.sv
// Shared types and helpers for the ChaCha20 core control logic.
package chacha_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  // Ceiling log2, usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int span = 1; span < value; span = span * 2) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_ring.sv
// One-hot position register with a matching binary index. Supports
// re-initialise to position 0, direct load and a circular one-step shift.
module onehot_ring #(
  parameter int DATA_BITS = 8,
  parameter int IDX_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 load,
  input  logic [IDX_BITS-1:0]  load_idx,
  input  logic                 shift,
  output logic [DATA_BITS-1:0] state,
  output logic [IDX_BITS-1:0]  idx,
  output logic                 wrap
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DATA_BITS - 1);

  logic at_last;

  assign at_last = (idx == LAST_IDX);

  // A shift taken from the last position returns to position 0 and ends a pass.
  assign wrap = shift && at_last;

  // Position register: init beats load beats shift; load_idx is assumed in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DATA_BITS'(1);
      idx   <= '0;
    end else if (init) begin
      state <= DATA_BITS'(1);
      idx   <= '0;
    end else if (load) begin
      state <= DATA_BITS'(1) << load_idx;
      idx   <= load_idx;
    end else if (shift) begin
      if (at_last) begin
        state <= DATA_BITS'(1);
        idx   <= '0;
      end else begin
        state <= state << 1;
        idx   <= idx + IDX_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// One-hot step sequencer for the ChaCha20 round schedule: start/busy/done
// handshake, multi-pass repeat (or free-running ring when REPEAT is 0),
// indexed load with range check, and a registered binary index.
module onehot_sequencer
  import chacha_pkg::*;
#(
  parameter  int DATA_BITS = 8,
  parameter  int REPEAT    = 10,
  localparam int IDX_BITS  = (clog2(DATA_BITS) > 1) ? clog2(DATA_BITS) : 1,
  localparam int PASS_BITS = (clog2(REPEAT + 1) > 1) ? clog2(REPEAT + 1) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_i,
  input  logic                 start_i,
  input  logic                 incr_i,
  input  logic                 load_i,
  input  logic [IDX_BITS-1:0]  load_idx_i,
  output logic [DATA_BITS-1:0] state_o,
  output logic [IDX_BITS-1:0]  idx_o,
  output logic [PASS_BITS-1:0] pass_o,
  output logic                 first_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [IDX_BITS:0]    DATA_LIMIT = (IDX_BITS + 1)'(DATA_BITS);
  localparam logic [PASS_BITS-1:0] REPEAT_CNT = PASS_BITS'(REPEAT);

  seq_state_t           fsm_q;
  seq_state_t           fsm_d;
  logic [PASS_BITS-1:0] pass_q;
  logic [PASS_BITS-1:0] pass_d;
  logic [PASS_BITS-1:0] pass_inc;
  logic                 done_q;
  logic                 done_d;
  logic                 err_q;
  logic                 err_d;
  logic                 load_ok;
  logic                 ring_init;
  logic                 ring_load;
  logic                 ring_shift;
  logic                 ring_wrap;

  // A load target is usable only if it names an existing position.
  assign load_ok = ({1'b0, load_idx_i} < DATA_LIMIT);

  // Ring controls follow the per-cycle priority init > load > start/incr.
  assign ring_init  = init_i || (!load_i && (fsm_q == SEQ_IDLE) && start_i);
  assign ring_load  = !init_i && load_i && load_ok;
  assign ring_shift = !init_i && !load_i && (fsm_q == SEQ_RUN) && incr_i;
  assign pass_inc   = pass_q + PASS_BITS'(1);

  onehot_ring #(
    .DATA_BITS (DATA_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_ring (
    .clk      (clk_i),
    .rst      (rst_i),
    .init     (ring_init),
    .load     (ring_load),
    .load_idx (load_idx_i),
    .shift    (ring_shift),
    .state    (state_o),
    .idx      (idx_o),
    .wrap     (ring_wrap)
  );

  // Sequencer state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q <= SEQ_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state, pass count and the done/err pulse requests.
  always_comb begin
    fsm_d  = fsm_q;
    pass_d = pass_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (init_i) begin
      fsm_d  = SEQ_IDLE;
      pass_d = '0;
    end else if (load_i) begin
      err_d = !load_ok;
    end else begin
      case (fsm_q)
        SEQ_IDLE: begin
          if (start_i) begin
            fsm_d  = SEQ_RUN;
            pass_d = '0;
          end
        end
        SEQ_RUN: begin
          if (ring_wrap) begin
            pass_d = pass_inc;
            if ((REPEAT != 0) && (pass_inc == REPEAT_CNT)) begin
              fsm_d  = SEQ_IDLE;
              done_d = 1'b1;
            end
          end
        end
        default: fsm_d = SEQ_IDLE;
      endcase
    end
  end

  // Pass counter and one-cycle status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pass_q <= pass_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign pass_o  = pass_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign busy_o  = (fsm_q == SEQ_RUN);
  assign first_o = state_o[0];
  assign last_o  = state_o[DATA_BITS-1];

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer: a 4-step, 2-pass instance for the
// handshake, load and priority cases, and a 3-step ring instance.
module tb_onehot_sequencer;

  logic clk;
  logic rst;

  logic       a_init, a_load, a_start, a_incr;
  logic [1:0] a_lidx;
  logic [3:0] a_state;
  logic [1:0] a_idx;
  logic [1:0] a_pass;
  logic       a_first, a_last, a_busy, a_done, a_err;

  logic       b_init, b_load, b_start, b_incr;
  logic [1:0] b_lidx;
  logic [2:0] b_state;
  logic [1:0] b_idx;
  logic [0:0] b_pass;
  logic       b_first, b_last, b_busy, b_done, b_err;

  int check_count;
  int error_count;
  bit b_done_seen;

  onehot_sequencer #(.DATA_BITS(4), .REPEAT(2)) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .init_i     (a_init),
    .start_i    (a_start),
    .incr_i     (a_incr),
    .load_i     (a_load),
    .load_idx_i (a_lidx),
    .state_o    (a_state),
    .idx_o      (a_idx),
    .pass_o     (a_pass),
    .first_o    (a_first),
    .last_o     (a_last),
    .busy_o     (a_busy),
    .done_o     (a_done),
    .err_o      (a_err)
  );

  onehot_sequencer #(.DATA_BITS(3), .REPEAT(0)) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .init_i     (b_init),
    .start_i    (b_start),
    .incr_i     (b_incr),
    .load_i     (b_load),
    .load_idx_i (b_lidx),
    .state_o    (b_state),
    .idx_o      (b_idx),
    .pass_o     (b_pass),
    .first_o    (b_first),
    .last_o     (b_last),
    .busy_o     (b_busy),
    .done_o     (b_done),
    .err_o      (b_err)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The ring instance must never signal completion.
  always @(posedge clk) begin
    if (b_done) b_done_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on instance a (sel=0) or b (sel=1), sample 1 ns after the edge.
  task automatic applyStimulus(input bit sel, input bit init, input bit load, input bit start,
                               input bit incr, input logic [1:0] lidx);
    a_init = 0; a_load = 0; a_start = 0; a_incr = 0; a_lidx = '0;
    b_init = 0; b_load = 0; b_start = 0; b_incr = 0; b_lidx = '0;
    if (!sel) begin
      a_init = init; a_load = load; a_start = start; a_incr = incr; a_lidx = lidx;
    end else begin
      b_init = init; b_load = load; b_start = start; b_incr = incr; b_lidx = lidx;
    end
    @(posedge clk);
    #1;
    if (!sel) begin
      checkOutput("a_onehot", 32'($onehot(a_state)), 1);
      checkOutput("a_idx_match", 32'(a_state), 32'(4'b0001 << a_idx));
    end else begin
      checkOutput("b_onehot", 32'($onehot(b_state)), 1);
      checkOutput("b_idx_match", 32'(b_state), 32'(3'b001 << b_idx));
    end
  endtask

  initial begin
    logic [3:0] exp_a_state [8];
    logic [1:0] exp_b_idx [7];
    exp_a_state = '{4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
    exp_b_idx   = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    check_count = 0;
    error_count = 0;
    b_done_seen = 1'b0;
    a_init = 0; a_load = 0; a_start = 0; a_incr = 0; a_lidx = '0;
    b_init = 0; b_load = 0; b_start = 0; b_incr = 0; b_lidx = '0;
    rst = 1'b1;
    #12;
    rst = 1'b0;

    checkOutput("rst_state", 32'(a_state), 1);
    checkOutput("rst_idx", 32'(a_idx), 0);
    checkOutput("rst_pass", 32'(a_pass), 0);
    checkOutput("rst_busy", 32'(a_busy), 0);
    checkOutput("rst_done", 32'(a_done), 0);
    checkOutput("rst_err", 32'(a_err), 0);
    checkOutput("rst_b_state", 32'(b_state), 1);

    // Start then two full passes of four steps.
    applyStimulus(0, 0, 0, 1, 0, 2'd0);
    checkOutput("start_busy", 32'(a_busy), 1);
    checkOutput("start_state", 32'(a_state), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 2'd0);
      checkOutput("seq_state", 32'(a_state), 32'(exp_a_state[i]));
      checkOutput("seq_done", 32'(a_done), (i == 7) ? 1 : 0);
      if (i == 3) begin
        checkOutput("seq_pass1", 32'(a_pass), 1);
        checkOutput("seq_busy1", 32'(a_busy), 1);
      end
    end
    checkOutput("end_pass", 32'(a_pass), 2);
    checkOutput("end_busy", 32'(a_busy), 0);
    checkOutput("end_first", 32'(a_first), 1);

    // Start during the done cycle restarts with no gap.
    applyStimulus(0, 0, 0, 1, 0, 2'd0);
    checkOutput("b2b_busy", 32'(a_busy), 1);
    checkOutput("b2b_pass", 32'(a_pass), 0);
    checkOutput("b2b_done", 32'(a_done), 0);

    // Start while running is ignored.
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    checkOutput("run_idx2", 32'(a_idx), 2);
    applyStimulus(0, 0, 0, 1, 0, 2'd0);
    checkOutput("start_in_run_idx", 32'(a_idx), 2);
    checkOutput("start_in_run_busy", 32'(a_busy), 1);

    // Reach pass 1, load the last position, then complete.
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    checkOutput("wrap_pass", 32'(a_pass), 1);
    checkOutput("wrap_idx", 32'(a_idx), 0);
    applyStimulus(0, 0, 1, 0, 1, 2'd3);
    checkOutput("load_state", 32'(a_state), 8);
    checkOutput("load_last", 32'(a_last), 1);
    checkOutput("load_pass", 32'(a_pass), 1);
    checkOutput("load_busy", 32'(a_busy), 1);
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    checkOutput("load_done", 32'(a_done), 1);
    checkOutput("load_done_pass", 32'(a_pass), 2);
    checkOutput("load_done_busy", 32'(a_busy), 0);

    // Increment in idle is ignored, done drops.
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    checkOutput("idle_incr_state", 32'(a_state), 1);
    checkOutput("idle_incr_busy", 32'(a_busy), 0);
    checkOutput("done_drop", 32'(a_done), 0);

    // Start with a concurrent increment: the increment is not honoured.
    applyStimulus(0, 0, 0, 1, 1, 2'd0);
    checkOutput("start_incr_busy", 32'(a_busy), 1);
    checkOutput("start_incr_idx", 32'(a_idx), 0);

    // Init beats load and increment.
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    checkOutput("pre_init_idx", 32'(a_idx), 1);
    applyStimulus(0, 1, 1, 0, 1, 2'd2);
    checkOutput("init_busy", 32'(a_busy), 0);
    checkOutput("init_state", 32'(a_state), 1);
    checkOutput("init_pass", 32'(a_pass), 0);
    checkOutput("init_done", 32'(a_done), 0);

    // Load in idle moves the position but not the FSM.
    applyStimulus(0, 0, 1, 0, 0, 2'd2);
    checkOutput("idle_load_state", 32'(a_state), 4);
    checkOutput("idle_load_busy", 32'(a_busy), 0);
    checkOutput("idle_load_err", 32'(a_err), 0);

    // Asynchronous reset while running takes effect before the next edge.
    applyStimulus(0, 0, 0, 1, 0, 2'd0);
    applyStimulus(0, 0, 0, 0, 1, 2'd0);
    checkOutput("pre_rst_idx", 32'(a_idx), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_state", 32'(a_state), 1);
    checkOutput("async_idx", 32'(a_idx), 0);
    checkOutput("async_busy", 32'(a_busy), 0);
    checkOutput("async_done", 32'(a_done), 0);
    #2;
    rst = 1'b0;

    // Ring instance: seven increments over three positions.
    applyStimulus(1, 0, 0, 1, 0, 2'd0);
    checkOutput("ring_busy", 32'(b_busy), 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 2'd0);
      checkOutput("ring_idx", 32'(b_idx), 32'(exp_b_idx[i]));
    end
    checkOutput("ring_state", 32'(b_state), 2);
    // Two wraps on a one-bit pass counter wrap back to zero.
    checkOutput("ring_pass", 32'(b_pass), 32'((2) % 2));
    checkOutput("ring_busy_end", 32'(b_busy), 1);

    // Out-of-range load flags an error and leaves the position alone.
    applyStimulus(1, 0, 1, 0, 1, 2'd3);
    checkOutput("err_pulse", 32'(b_err), 1);
    checkOutput("err_state", 32'(b_state), 2);
    checkOutput("err_idx", 32'(b_idx), 1);
    applyStimulus(1, 0, 0, 0, 0, 2'd0);
    checkOutput("err_drop", 32'(b_err), 0);
    applyStimulus(1, 0, 1, 0, 0, 2'd2);
    checkOutput("ring_load_state", 32'(b_state), 4);
    checkOutput("ring_load_err", 32'(b_err), 0);
    checkOutput("ring_no_done", 32'(b_done_seen), 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
